// File: rtl/alu_op_driver.sv
// ---------------------------------------------------------------------------
// alu_op_driver
//
// Purpose:
//   Accepts one ALU command at a time over a valid/ready handshake, launches
//   it on a multi-cycle ALU with a one-cycle start pulse, waits for Done
//   (bounded by TIMEOUT_CYCLES), then presents the result over a valid/ready
//   response handshake.
//
// State table:
//   state | meaning
//   IDLE  | cmd_ready=1, waiting for a command
//   ISSUE | start=1 for one cycle, operands/opcode driven to the ALU
//   WAIT  | operands held, watching Done, counting toward the timeout
//   RESP  | rsp_valid=1, response held until rsp_ready
//
// Parameters:
//   TIMEOUT_CYCLES  number of WAIT cycles without Done before the op is
//                   abandoned with rsp_timeout=1 (legal range 1..255)
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_a, cmd_b         4-bit operands
//   cmd_op               00 add, 01 sub, 10 mul, 11 div
//   A, B, opcode, start  ALU drive (A/B/opcode zero outside ISSUE/WAIT)
//   Result, Done, Error  ALU completion (ignored outside WAIT)
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           verbatim copy of ALU Result
//   rsp_error            captured ALU Error
//   rsp_timeout          op abandoned because no Done arrived
//
// Optional feature (macro ALU_DRV_STATS_EN):
//   stat_ops, stat_errs, stat_tmo  8-bit wrapping counters of delivered
//   responses, error responses and timeout responses.
// ---------------------------------------------------------------------------
module alu_op_driver #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [1:0] opcode,
    output logic       start,
    input  logic [7:0] Result,
    input  logic       Done,
    input  logic       Error,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_error,
    output logic       rsp_timeout
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [7:0] stat_ops,
    output logic [7:0] stat_errs,
    output logic [7:0] stat_tmo
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter value on the last WAIT edge before the op is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_cmd_ready;
    logic       r_start;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [1:0] r_op;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_result;
    logic       r_rsp_error;
    logic       r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            r_cmd_ready   <= 1'b1;
            r_start       <= 1'b0;
            r_a           <= 4'd0;
            r_b           <= 4'd0;
            r_op          <= 2'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= 8'd0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The operand registers double as the ALU drive, so the
                    // command is captured straight into them.
                    if (cmd_valid) begin
                        r_a         <= cmd_a;
                        r_b         <= cmd_b;
                        r_op        <= cmd_op;
                        r_start     <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so it wins over a same-edge timeout.
                    if (Done) begin
                        r_rsp_result  <= Result;
                        r_rsp_error   <= Error;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_a           <= 4'd0;
                        r_b           <= 4'd0;
                        r_op          <= 2'd0;
                        r_state       <= RESP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_rsp_result  <= 8'd0;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_a           <= 4'd0;
                        r_b           <= 4'd0;
                        r_op          <= 2'd0;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_start     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign start       = r_start;
    assign A           = r_a;
    assign B           = r_b;
    assign opcode      = r_op;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;

`ifdef ALU_DRV_STATS_EN
    logic       w_rsp_fire;
    logic [7:0] r_stat_ops;
    logic [7:0] r_stat_errs;
    logic [7:0] r_stat_tmo;

    assign w_rsp_fire = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_ops  <= 8'd0;
            r_stat_errs <= 8'd0;
            r_stat_tmo  <= 8'd0;
        end else if (w_rsp_fire) begin
            r_stat_ops <= r_stat_ops + 8'd1;
            if (r_rsp_error)
                r_stat_errs <= r_stat_errs + 8'd1;
            if (r_rsp_timeout)
                r_stat_tmo <= r_stat_tmo + 8'd1;
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
    assign stat_tmo  = r_stat_tmo;
`endif

endmodule
